// File: rtl/wb_burst_ram.sv
// rtl/wb_burst_ram.sv - Wishbone B3 burst-capable slave memory with byte-lane writes
module wb_burst_ram #(
    parameter int dw = 32,
    parameter int aw = 32,
    parameter int DEPTH_BITS = 8,
    parameter logic [aw-1:0] BASE_ADR = '0
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic [aw-1:0] wb_adr_i,
    input  logic [dw-1:0] wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic [2:0]    wb_cti_i,
    input  logic [1:0]    wb_bte_i,
    output logic [dw-1:0] wb_sdt_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          wb_rty_o
);

    localparam int DEPTH = 2 ** DEPTH_BITS;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t                state_q, state_n;
    logic                  ack_q, ack_n;
    logic                  err_q, err_n;
    logic [dw-1:0]         sdt_q, sdt_n;
    logic [DEPTH_BITS-1:0] cur_idx, idx_n;
    logic [DEPTH_BITS-1:0] adr_idx, burst_idx, wrap_mask;
    logic [dw-1:0]         mem [DEPTH];
    logic [dw-1:0]         wr_merged;
    logic                  in_range, start, beat, wr_en, load;
    logic                  unused_adr;

    // BASE_ADR is aligned to the memory size, so range check and index are plain bit slices.
    assign adr_idx    = wb_adr_i[DEPTH_BITS+1:2];
    assign in_range   = (wb_adr_i[aw-1:DEPTH_BITS+2] == BASE_ADR[aw-1:DEPTH_BITS+2]);
    assign unused_adr = ^wb_adr_i[1:0];

    assign beat  = wb_cyc_i & wb_stb_i & ack_q;
    assign wr_en = beat & wb_we_i;
    assign start = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;

    always_comb begin
        wrap_mask = '1;
        case (wb_bte_i)
            2'b01:   wrap_mask = DEPTH_BITS'(3);
            2'b10:   wrap_mask = DEPTH_BITS'(7);
            2'b11:   wrap_mask = DEPTH_BITS'(15);
            default: wrap_mask = '1;
        endcase
    end

    always_comb begin
        burst_idx = cur_idx;
        if (wb_cti_i == 3'b010) begin
            burst_idx = (cur_idx & ~wrap_mask) | ((cur_idx + DEPTH_BITS'(1)) & wrap_mask);
        end
    end

    always_comb begin
        wr_merged = mem[cur_idx];
        for (int i = 0; i < 4; i++) begin
            if (wb_sel_i[i]) begin
                wr_merged[8*i +: 8] = wb_dat_i[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_n = state_q;
        ack_n   = 1'b0;
        err_n   = 1'b0;
        idx_n   = cur_idx;
        load    = 1'b0;
        if (!wb_cyc_i) begin
            state_n = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (in_range) begin
                            ack_n = 1'b1;
                            idx_n = adr_idx;
                            load  = 1'b1;
                            if (wb_cti_i == 3'b001 || wb_cti_i == 3'b010) begin
                                state_n = BURST;
                            end
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end
                BURST: begin
                    if (beat) begin
                        if (wb_cti_i == 3'b111) begin
                            state_n = IDLE;
                        end else begin
                            ack_n = 1'b1;
                            idx_n = burst_idx;
                            load  = 1'b1;
                        end
                    end else if (wb_stb_i) begin
                        ack_n = 1'b1;
                        load  = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Prefetch forwards a same-cycle write so write-then-read of one word sees new data.
    always_comb begin
        sdt_n = sdt_q;
        if (load) begin
            sdt_n = (wr_en && idx_n == cur_idx) ? wr_merged : mem[idx_n];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            sdt_q   <= '0;
            cur_idx <= '0;
        end else begin
            state_q <= state_n;
            ack_q   <= ack_n;
            err_q   <= err_n;
            sdt_q   <= sdt_n;
            cur_idx <= idx_n;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_ni && wr_en) begin
            mem[cur_idx] <= wr_merged;
        end
    end

    assign wb_sdt_o = sdt_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_burst_ram.sv
// tb/tb_wb_burst_ram.sv - directed self-checking bench for wb_burst_ram
module tb_wb_burst_ram;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] adr, dat, sdt;
    logic [3:0]  sel;
    logic        we, cyc, stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack, err, rty;

    int          compared = 0;
    int          mismatched = 0;
    logic [31:0] bv [16];
    logic [31:0] rd;

    always #5 clk = ~clk;

    wb_burst_ram #(
        .dw(32),
        .aw(32),
        .DEPTH_BITS(8),
        .BASE_ADR(BASE)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .wb_adr_i (adr),
        .wb_dat_i (dat),
        .wb_sel_i (sel),
        .wb_we_i  (we),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_cti_i (cti),
        .wb_bte_i (bte),
        .wb_sdt_o (sdt),
        .wb_ack_o (ack),
        .wb_err_o (err),
        .wb_rty_o (rty)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic idle_bus;
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        cti = 3'b000;
        bte = 2'b00;
        sel = 4'hF;
    endtask

    task automatic classic(input string tag, input logic [31:0] a, input logic w,
                           input logic [31:0] d, input logic [3:0] s,
                           input logic exp_err, output logic [31:0] r);
        adr = a; we = w; dat = d; sel = s; cti = 3'b000; cyc = 1'b1; stb = 1'b1;
        step;
        check({tag, "_ack"}, {31'b0, ack}, {31'b0, !exp_err});
        check({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
        r = sdt;
        step;
        check({tag, "_drop"}, {30'b0, ack, err}, 32'h0);
        idle_bus;
    endtask

    task automatic burst(input string tag, input int widx, input int n, input logic w,
                         input logic [2:0] mode, input logic [1:0] b);
        adr = BASE + 32'(widx * 4); we = w; sel = 4'hF; bte = b; dat = bv[0];
        cti = (n == 1) ? 3'b111 : mode;
        cyc = 1'b1; stb = 1'b1;
        for (int k = 0; k < n; k++) begin
            step;
            check($sformatf("%s_ack%0d", tag, k), {31'b0, ack}, 32'd1);
            if (!w) check($sformatf("%s_dat%0d", tag, k), sdt, bv[k]);
            dat = bv[k];
            cti = (k == n - 1) ? 3'b111 : mode;
        end
        step;
        check({tag, "_end"}, {31'b0, ack}, 32'd0);
        idle_bus;
    endtask

    initial begin
        rst_n = 1'b0; adr = '0; dat = '0;
        idle_bus;
        repeat (3) step;
        check("rst_ack", {31'b0, ack}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_sdt", sdt, 32'd0);
        check("rst_rty", {31'b0, rty}, 32'd0);
        rst_n = 1'b1;
        step;

        classic("cw1", BASE + 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0, rd);
        classic("cr1", BASE + 32'h10, 1'b0, 32'h0, 4'hF, 1'b0, rd);
        check("cr1_dat", rd, 32'hDEADBEEF);
        classic("cw2", BASE + 32'h10, 1'b1, 32'h000000AA, 4'b0001, 1'b0, rd);
        classic("cr2", BASE + 32'h10, 1'b0, 32'h0, 4'hF, 1'b0, rd);
        check("cr2_dat", rd, 32'hDEADBEAA);

        for (int i = 0; i < 5; i++) bv[i] = 32'(i + 1);
        burst("lw", 2, 5, 1'b1, 3'b010, 2'b00);
        burst("lr", 2, 5, 1'b0, 3'b010, 2'b00);

        for (int i = 0; i < 4; i++) classic("w4w", BASE + 32'(i * 4), 1'b1, 32'hA0 + 32'(i * 16), 4'hF, 1'b0, rd);
        bv[0] = 32'hC0; bv[1] = 32'hD0; bv[2] = 32'hA0; bv[3] = 32'hB0;
        burst("w4r", 2, 4, 1'b0, 3'b010, 2'b01);

        for (int i = 0; i < 8; i++) bv[i] = 32'(i);
        burst("l8w", 0, 8, 1'b1, 3'b010, 2'b00);
        for (int i = 0; i < 8; i++) bv[i] = 32'((i + 6) % 8);
        burst("w8r", 6, 8, 1'b0, 3'b010, 2'b10);

        classic("k8w", BASE + 32'h20, 1'b1, 32'h88, 4'hF, 1'b0, rd);
        classic("k10w", BASE + 32'h28, 1'b1, 32'h1010, 4'hF, 1'b0, rd);
        bv[0] = 32'd1; bv[1] = 32'd2; bv[2] = 32'd3;
        burst("kw", 9, 3, 1'b1, 3'b001, 2'b00);
        classic("k8r", BASE + 32'h20, 1'b0, 32'h0, 4'hF, 1'b0, rd);
        check("k8_dat", rd, 32'h88);
        classic("k9r", BASE + 32'h24, 1'b0, 32'h0, 4'hF, 1'b0, rd);
        check("k9_dat", rd, 32'h3);
        classic("k10r", BASE + 32'h28, 1'b0, 32'h0, 4'hF, 1'b0, rd);
        check("k10_dat", rd, 32'h1010);

        adr = BASE + 32'h08; we = 1'b0; cti = 3'b010; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
        step;
        check("ws_b0", sdt, 32'd2);
        step;
        check("ws_b1", sdt, 32'd3);
        step;
        check("ws_b2_ack", {31'b0, ack}, 32'd1);
        check("ws_b2", sdt, 32'd4);
        stb = 1'b0;
        step;
        check("ws_gap0", {31'b0, ack}, 32'd0);
        step;
        check("ws_gap1", {31'b0, ack}, 32'd0);
        stb = 1'b1;
        step;
        check("ws_resume_ack", {31'b0, ack}, 32'd1);
        check("ws_resume", sdt, 32'd4);
        step;
        check("ws_b3", sdt, 32'd5);
        cti = 3'b111;
        step;
        check("ws_end", {31'b0, ack}, 32'd0);
        idle_bus;

        for (int i = 0; i < 4; i++) bv[i] = 32'hE0 + 32'(i);
        burst("pf", 20, 4, 1'b1, 3'b010, 2'b00);
        adr = BASE + 32'h50; we = 1'b1; sel = 4'hF; cti = 3'b010; dat = 32'hF0; cyc = 1'b1; stb = 1'b1;
        step;
        check("ab_b0", {31'b0, ack}, 32'd1);
        step;
        check("ab_b1", {31'b0, ack}, 32'd1);
        dat = 32'hF1; cyc = 1'b0; stb = 1'b0;
        step;
        check("ab_drop", {30'b0, ack, err}, 32'd0);
        idle_bus;
        bv[0] = 32'hF0; bv[1] = 32'hE1; bv[2] = 32'hE2; bv[3] = 32'hE3;
        burst("ar", 20, 4, 1'b0, 3'b010, 2'b00);

        classic("top_w", BASE + 32'h3FC, 1'b1, 32'hFF, 4'hF, 1'b0, rd);
        bv[0] = 32'hFF; bv[1] = 32'h0;
        burst("er", 255, 2, 1'b0, 3'b010, 2'b00);

        classic("oor", BASE + 32'h400, 1'b1, 32'h12345678, 4'hF, 1'b1, rd);
        classic("oor_chk", BASE, 1'b0, 32'h0, 4'hF, 1'b0, rd);
        check("oor_dat", rd, 32'h0);
        classic("low", BASE - 32'h4, 1'b0, 32'h0, 4'hF, 1'b1, rd);

        classic("r30w", BASE + 32'h78, 1'b1, 32'h30, 4'hF, 1'b0, rd);
        classic("r31w", BASE + 32'h7C, 1'b1, 32'h31, 4'hF, 1'b0, rd);
        adr = BASE + 32'h78; we = 1'b1; sel = 4'hF; cti = 3'b010; dat = 32'hA30; cyc = 1'b1; stb = 1'b1;
        step;
        check("rb_b0", {31'b0, ack}, 32'd1);
        step;
        check("rb_b1", {31'b0, ack}, 32'd1);
        dat = 32'hA31; rst_n = 1'b0;
        step;
        check("rb_ack", {31'b0, ack}, 32'd0);
        check("rb_err", {31'b0, err}, 32'd0);
        check("rb_sdt", sdt, 32'd0);
        rst_n = 1'b1;
        idle_bus;
        step;
        classic("rb30", BASE + 32'h78, 1'b0, 32'h0, 4'hF, 1'b0, rd);
        check("rb30_dat", rd, 32'hA30);
        classic("rb31", BASE + 32'h7C, 1'b0, 32'h0, 4'hF, 1'b0, rd);
        check("rb31_dat", rd, 32'h31);
        classic("rb9", BASE + 32'h24, 1'b0, 32'h0, 4'hF, 1'b0, rd);
        check("rb9_dat", rd, 32'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
